fir_window_peak: RTL and testbench

//  Downstream stage of the symmetric FIR filter (symetryczny): consumes its signed 10-bit y_out

---
 rtl/fir_window_peak_if.sv | 31 +++
 rtl/fir_window_peak.sv | 141 ++++++++++++++
 tb/tb_fir_window_peak.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fir_window_peak_if.sv
// Sample-stream and result-handshake bundle for fir_window_peak.
//  master: drives samples, clear and res_ready; observes the window results.
//  slave : the window-peak block itself.
//  Signals: clear, y_in[DW], y_valid, res_ready -> slave
//           pk_max[DW], pk_min[DW], abs_sum[SUM_W], res_valid, overrun -> master
interface fir_window_peak_if #(
    parameter int unsigned DW  = 10,
    parameter int unsigned WIN = 8
);
    localparam int unsigned SUM_W = DW + $clog2(WIN);

    logic             clear;
    logic [DW-1:0]    y_in;
    logic             y_valid;
    logic             res_ready;
    logic [DW-1:0]    pk_max;
    logic [DW-1:0]    pk_min;
    logic [SUM_W-1:0] abs_sum;
    logic             res_valid;
    logic             overrun;

    modport master (
        output clear, y_in, y_valid, res_ready,
        input  pk_max, pk_min, abs_sum, res_valid, overrun
    );

    modport slave (
        input  clear, y_in, y_valid, res_ready,
        output pk_max, pk_min, abs_sum, res_valid, overrun
    );
endinterface

// File: rtl/fir_window_peak.sv
// Window peak/level monitor behind the symmetric FIR output.
// Over consecutive non-overlapping windows of WIN accepted samples it computes the signed
// max, signed min and saturating sum of |y|, and holds the result for a consumer behind
// a valid/ready handshake with a sticky overrun flag.
//  clk   : rising-edge clock
//  rst   : asynchronous reset, active low
//  sl    : fir_window_peak_if.slave (samples in, clear, result handshake out)
module fir_window_peak #(
    parameter int unsigned DW  = 10,
    parameter int unsigned WIN = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_window_peak_if.slave     sl
);
    localparam int unsigned SUM_W = DW + $clog2(WIN);
    localparam int unsigned SUM_X = SUM_W + 1;
    localparam int unsigned CNT_W = (WIN > 2) ? $clog2(WIN) : 1;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_ACC   = 1'b1;

    logic [0:0]              state_q,   state_d;
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic signed [DW-1:0]    acc_max_q, acc_max_d;
    logic signed [DW-1:0]    acc_min_q, acc_min_d;
    logic [SUM_W-1:0]        acc_sum_q, acc_sum_d;
    logic signed [DW-1:0]    pk_max_q,  pk_max_d;
    logic signed [DW-1:0]    pk_min_q,  pk_min_d;
    logic [SUM_W-1:0]        abs_sum_q, abs_sum_d;
    logic                    res_valid_q, res_valid_d;
    logic                    overrun_q,   overrun_d;

    logic signed [DW-1:0]    y_s_c;
    logic [DW-1:0]           y_abs_c;
    logic [SUM_X-1:0]        sum_ext_c;
    logic [SUM_W-1:0]        sum_sat_c;
    logic signed [DW-1:0]    max_upd_c;
    logic signed [DW-1:0]    min_upd_c;

    // Magnitude is unsigned DW bits, so the most negative sample maps to 2**(DW-1) without wrap.
    always_comb begin
        y_s_c     = $signed(sl.y_in);
        y_abs_c   = sl.y_in[DW-1] ? (~sl.y_in + DW'(1)) : sl.y_in;
        sum_ext_c = {1'b0, acc_sum_q} + SUM_X'(y_abs_c);
        sum_sat_c = sum_ext_c[SUM_W] ? {SUM_W{1'b1}} : sum_ext_c[SUM_W-1:0];
        max_upd_c = (y_s_c > acc_max_q) ? y_s_c : acc_max_q;
        min_upd_c = (y_s_c < acc_min_q) ? y_s_c : acc_min_q;
    end

    // Accumulator FSM and result handshake next-state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_max_d   = acc_max_q;
        acc_min_d   = acc_min_q;
        acc_sum_d   = acc_sum_q;
        pk_max_d    = pk_max_q;
        pk_min_d    = pk_min_q;
        abs_sum_d   = abs_sum_q;
        res_valid_d = res_valid_q;
        overrun_d   = overrun_q;

        if (sl.clear) begin
            // Restart the window and drop any pending result; result data stays visible.
            state_d     = ST_EMPTY;
            cnt_d       = '0;
            res_valid_d = 1'b0;
            overrun_d   = 1'b0;
        end else begin
            if (res_valid_q && sl.res_ready) begin
                res_valid_d = 1'b0;
            end

            if (sl.y_valid) begin
                case (state_q)
                    ST_EMPTY: begin
                        acc_max_d = y_s_c;
                        acc_min_d = y_s_c;
                        acc_sum_d = SUM_W'(y_abs_c);
                        cnt_d     = CNT_W'(1);
                        state_d   = ST_ACC;
                    end
                    default: begin
                        if (cnt_q == CNT_W'(WIN - 1)) begin
                            // Last sample: publish including this sample, overwrite if unconsumed.
                            pk_max_d    = max_upd_c;
                            pk_min_d    = min_upd_c;
                            abs_sum_d   = sum_sat_c;
                            res_valid_d = 1'b1;
                            if (res_valid_q && !sl.res_ready) begin
                                overrun_d = 1'b1;
                            end
                            cnt_d   = '0;
                            state_d = ST_EMPTY;
                        end else begin
                            acc_max_d = max_upd_c;
                            acc_min_d = min_upd_c;
                            acc_sum_d = sum_sat_c;
                            cnt_d     = cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_EMPTY;
            cnt_q       <= '0;
            acc_max_q   <= '0;
            acc_min_q   <= '0;
            acc_sum_q   <= '0;
            pk_max_q    <= '0;
            pk_min_q    <= '0;
            abs_sum_q   <= '0;
            res_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_max_q   <= acc_max_d;
            acc_min_q   <= acc_min_d;
            acc_sum_q   <= acc_sum_d;
            pk_max_q    <= pk_max_d;
            pk_min_q    <= pk_min_d;
            abs_sum_q   <= abs_sum_d;
            res_valid_q <= res_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sl.pk_max    = pk_max_q;
    assign sl.pk_min    = pk_min_q;
    assign sl.abs_sum   = abs_sum_q;
    assign sl.res_valid = res_valid_q;
    assign sl.overrun   = overrun_q;

endmodule

// File: tb/tb_fir_window_peak.sv
// Self-checking bench for fir_window_peak (DW=10, WIN=8): directed scenarios with
// hand-derived constants plus randomized traffic against a queue-based window model.
module tb_fir_window_peak;
    localparam int unsigned DW    = 10;
    localparam int unsigned WIN   = 8;
    localparam int unsigned SUM_W = DW + $clog2(WIN);
    localparam int          SUM_MAX = (1 << SUM_W) - 1;

    logic clk = 1'b0;
    logic rst;

    fir_window_peak_if #(.DW(DW), .WIN(WIN)) ifc ();

    fir_window_peak #(.DW(DW), .WIN(WIN)) dut (
        .clk (clk),
        .rst (rst),
        .sl  (ifc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: samples of the window in progress and the published result.
    int win_q[$];
    bit exp_valid;
    bit exp_ovr;
    int exp_max;
    int exp_min;
    int exp_sum;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        win_q.delete();
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        exp_max   = 0;
        exp_min   = 0;
        exp_sum   = 0;
    endtask

    // One rising edge of the model with the inputs that were applied before it.
    task automatic model_edge(input bit v, input int y, input bit rdy, input bit clr);
        int mx, mn, sm;
        if (clr) begin
            win_q.delete();
            exp_valid = 1'b0;
            exp_ovr   = 1'b0;
        end else begin
            bit done = 1'b0;
            if (v) begin
                win_q.push_back(y);
                if (win_q.size() == WIN) begin
                    mx = win_q[0];
                    mn = win_q[0];
                    sm = 0;
                    foreach (win_q[i]) begin
                        if (win_q[i] > mx) mx = win_q[i];
                        if (win_q[i] < mn) mn = win_q[i];
                        sm += (win_q[i] < 0) ? -win_q[i] : win_q[i];
                    end
                    if (sm > SUM_MAX) sm = SUM_MAX;
                    done = 1'b1;
                    win_q.delete();
                end
            end
            if (done) begin
                if (exp_valid && !rdy) exp_ovr = 1'b1;
                exp_valid = 1'b1;
                exp_max   = mx;
                exp_min   = mn;
                exp_sum   = sm;
            end else if (exp_valid && rdy) begin
                exp_valid = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        check_val("res_valid", int'(ifc.res_valid), int'(exp_valid));
        check_val("overrun",   int'(ifc.overrun),   int'(exp_ovr));
        check_val("pk_max",    int'($signed(ifc.pk_max)), exp_max);
        check_val("pk_min",    int'($signed(ifc.pk_min)), exp_min);
        check_val("abs_sum",   int'(ifc.abs_sum), exp_sum);
    endtask

    // Apply inputs, take one edge, advance the model, check 1 time unit after the edge.
    task automatic cyc(input bit v, input int y, input bit rdy, input bit clr);
        ifc.y_valid   = v;
        ifc.y_in      = DW'(y);
        ifc.res_ready = rdy;
        ifc.clear     = clr;
        @(posedge clk);
        model_edge(v, y, rdy, clr);
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, rdy, 1'b0);
    endtask

    task automatic check_result(input string tag, input int mx, input int mn, input int sm);
        check_val({tag, "_valid"}, int'(ifc.res_valid), 1);
        check_val({tag, "_max"},   int'($signed(ifc.pk_max)), mx);
        check_val({tag, "_min"},   int'($signed(ifc.pk_min)), mn);
        check_val({tag, "_sum"},   int'(ifc.abs_sum), sm);
    endtask

    initial begin
        int bp2[8];
        bp2 = '{5, -7, 100, -200, 3, 0, 9, -1};

        rst           = 1'b0;
        ifc.clear     = 1'b0;
        ifc.y_in      = '0;
        ifc.y_valid   = 1'b0;
        ifc.res_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_valid",   int'(ifc.res_valid), 0);
        check_val("rst_overrun", int'(ifc.overrun), 0);
        check_val("rst_max",     int'($signed(ifc.pk_max)), 0);
        check_val("rst_sum",     int'(ifc.abs_sum), 0);
        rst = 1'b1;

        // Impulse window.
        cyc(1'b1, 1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 0, 1'b1, 1'b0);
        check_result("imp", 1, 0, 1);
        cyc(1'b0, 0, 1'b1, 1'b0);
        check_val("imp_valid_drop", int'(ifc.res_valid), 0);

        // Extreme values: magnitude of -512 must not wrap.
        for (int i = 0; i < 8; i++) cyc(1'b1, -512, 1'b1, 1'b0);
        check_result("neg", -512, -512, 4096);
        idle(1, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b1, 511, 1'b1, 1'b0);
        check_result("pos", 511, 511, 4088);
        idle(1, 1'b1);

        // Alternating extremes separated by random gaps.
        for (int i = 0; i < 8; i++) begin
            idle(int'($urandom_range(0, 3)), 1'b1);
            if (i == 7) check_val("alt_pre_valid", int'(ifc.res_valid), 0);
            cyc(1'b1, (i % 2 == 0) ? 511 : -512, 1'b1, 1'b0);
        end
        check_result("alt", 511, -512, 4092);
        idle(2, 1'b1);

        // Backpressure across two windows.
        for (int i = 0; i < 8; i++) cyc(1'b1, int'($urandom_range(0, 1023)) - 512, 1'b0, 1'b0);
        check_val("bp_first_ovr", int'(ifc.overrun), 0);
        for (int i = 0; i < 8; i++) cyc(1'b1, bp2[i], 1'b0, 1'b0);
        check_val("bp_ovr", int'(ifc.overrun), 1);
        check_result("bp2", 100, -200, 325);
        cyc(1'b0, 0, 1'b1, 1'b0);
        check_val("bp_drain", int'(ifc.res_valid), 0);
        check_val("bp_ovr_sticky", int'(ifc.overrun), 1);
        idle(2, 1'b1);
        cyc(1'b0, 0, 1'b0, 1'b1);
        check_val("clr_ovr", int'(ifc.overrun), 0);
        check_val("clr_keep_max", int'($signed(ifc.pk_max)), 100);

        // Asynchronous reset mid-window.
        for (int i = 0; i < 5; i++) cyc(1'b1, 10 + i, 1'b1, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_valid", int'(ifc.res_valid), 0);
        check_val("arst_max",   int'($signed(ifc.pk_max)), 0);
        check_val("arst_min",   int'($signed(ifc.pk_min)), 0);
        check_val("arst_sum",   int'(ifc.abs_sum), 0);
        model_reset();
        ifc.y_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        cyc(1'b1, 3, 1'b1, 1'b0);
        cyc(1'b1, -3, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, 0, 1'b1, 1'b0);
        check_result("post_rst", 3, -3, 6);
        idle(1, 1'b1);

        // Clear on the 8th sample with a result pending.
        for (int i = 0; i < 8; i++) cyc(1'b1, 20, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 30, 1'b0, 1'b0);
        cyc(1'b1, 50, 1'b1, 1'b1);
        check_val("clr8_valid", int'(ifc.res_valid), 0);
        check_val("clr8_ovr",   int'(ifc.overrun), 0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 2, 1'b1, 1'b0);
        check_val("clr8_restart_pre", int'(ifc.res_valid), 0);
        cyc(1'b1, -2, 1'b1, 1'b0);
        check_result("clr8_restart", 2, -2, 16);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                int'($urandom_range(0, 1023)) - 512,
                $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
